// File: rtl/mon_commit_serializer_if.sv
// mon_commit_serializer_if
//   Groups the retire-side bus and the serialized output stream of
//   mon_commit_serializer.
//   master : the environment. It drives the retire slots and out_ready, and it
//            samples the serialized record.
//   slave  : the serializer. It samples the retire slots and drives the
//            serialized record.
//   Retire slot c occupies bits [W*c +: W] of each packed field.
interface mon_commit_serializer_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]    in_valid;
  logic [64*CHANNELS-1:0] in_order;
  logic [32*CHANNELS-1:0] in_inst;
  logic [32*CHANNELS-1:0] in_pc_rdata;
  logic [32*CHANNELS-1:0] in_pc_wdata;
  logic [5*CHANNELS-1:0]  in_rd_addr;
  logic [32*CHANNELS-1:0] in_rd_wdata;
  logic [CHANNELS-1:0]    in_halt;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_order;
  logic [31:0] out_inst;
  logic [31:0] out_pc_rdata;
  logic [31:0] out_pc_wdata;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_wdata;
  logic        out_halt;

  modport master (
    output in_valid, in_order, in_inst, in_pc_rdata, in_pc_wdata,
           in_rd_addr, in_rd_wdata, in_halt, out_ready,
    input  out_valid, out_order, out_inst, out_pc_rdata, out_pc_wdata,
           out_rd_addr, out_rd_wdata, out_halt
  );

  modport slave (
    input  in_valid, in_order, in_inst, in_pc_rdata, in_pc_wdata,
           in_rd_addr, in_rd_wdata, in_halt, out_ready,
    output out_valid, out_order, out_inst, out_pc_rdata, out_pc_wdata,
           out_rd_addr, out_rd_wdata, out_halt
  );
endinterface

// File: rtl/mon_commit_serializer.sv
// mon_commit_serializer
//   Commit monitor for multi-retire CPUs. The block samples up to CHANNELS
//   retirement records per cycle and checks program-order invariants. It
//   buffers the accepted groups in a DEPTH-entry FIFO and replays them one
//   record per cycle over a valid/ready stream.
//
//   Ports
//     clk, rst          clock, synchronous active-high reset
//     bus (slave)       retire slots in, serialized record out
//     error_o           sticky, set by the first detected violation
//     error_code_o      code of that first violation:
//                         1 order gap, 2 non-contiguous slots,
//                         3 PC discontinuity, 4 overflow, 5 timeout,
//                         6 x0 write, 7 commit after halt
//     commit_count_o    records accepted into the FIFO
//     halted_o          a halt record has been accepted
//
//   Build option
//     MON_PC_CHECK_EN   When this macro is defined, the block compiles in
//                       last_pc_wdata and the code-3 PC continuity check.
module mon_commit_serializer #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 10000
) (
  input  logic                  clk,
  input  logic                  rst,
  mon_commit_serializer_if.slave bus,
  output logic                  error_o,
  output logic [2:0]            error_code_o,
  output logic [63:0]           commit_count_o,
  output logic                  halted_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(CHANNELS + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        halt;
  } rec_t;

  rec_t          mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   exp_order_q;
  logic [63:0]   commit_q;
  logic [TW-1:0] idle_q, idle_d;
  logic          halted_q;
  logic          err_q;
  logic [2:0]    code_q;
`ifdef MON_PC_CHECK_EN
  logic [31:0]   last_pc_q, last_pc_d;
  logic          last_pc_vld_q;
  logic [31:0]   prev_pc;
  logic          prev_vld;
`endif

  rec_t          slot [CHANNELS];
  logic [NW-1:0] n;
  logic          c1, c2, c3, c4, c5, c6, c7;
  logic          any_halt, drop, push, pop;
  logic [2:0]    code;
  rec_t          head;

  always_comb begin
    n        = '0;
    c1       = 1'b0;
    c2       = 1'b0;
    c3       = 1'b0;
    c6       = 1'b0;
    c7       = 1'b0;
    any_halt = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      slot[c].order    = bus.in_order[64*c +: 64];
      slot[c].inst     = bus.in_inst[32*c +: 32];
      slot[c].pc_rdata = bus.in_pc_rdata[32*c +: 32];
      slot[c].pc_wdata = bus.in_pc_wdata[32*c +: 32];
      slot[c].rd_addr  = bus.in_rd_addr[5*c +: 5];
      slot[c].rd_wdata = bus.in_rd_wdata[32*c +: 32];
      slot[c].halt     = bus.in_halt[c];
      if (bus.in_valid[c]) begin
        n = n + NW'(1);
        // The expected order is tied to the physical slot index.
        if (slot[c].order != exp_order_q + 64'(c)) c1 = 1'b1;
        if (slot[c].rd_addr == 5'd0 && slot[c].rd_wdata != 32'd0) c6 = 1'b1;
        if (halted_q) c7 = 1'b1;
        if (slot[c].halt) any_halt = 1'b1;
      end
    end
    for (int c = 1; c < CHANNELS; c++) begin
      if (bus.in_valid[c] && !bus.in_valid[c-1]) c2 = 1'b1;
    end
`ifdef MON_PC_CHECK_EN
    // Each valid record chains to the previous valid record. The first
    // valid record of the group chains to the last record of the
    // previously pushed group.
    prev_pc  = last_pc_q;
    prev_vld = last_pc_vld_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.in_valid[c]) begin
        if (prev_vld && slot[c].pc_rdata != prev_pc) c3 = 1'b1;
        prev_pc  = slot[c].pc_wdata;
        prev_vld = 1'b1;
      end
    end
    last_pc_d = prev_pc;
`endif

    // Overflow uses the occupancy from before this cycle's pop, so a pop
    // in the same cycle does not free a slot for this group.
    c4 = int'(n) > (DEPTH - int'(count_q));

    drop = c2 | c4 | c7;
    push = (n != '0) && !drop;
    pop  = (count_q != '0) && bus.out_ready;

    if (TIMEOUT == 0) begin
      idle_d = '0;
      c5     = 1'b0;
    end else begin
      if (push)                        idle_d = '0;
      else if (halted_q)               idle_d = idle_q;
      else if (idle_q == TW'(TIMEOUT)) idle_d = idle_q;
      else                             idle_d = idle_q + TW'(1);
      c5 = !halted_q && (idle_d == TW'(TIMEOUT));
    end

    if      (c1) code = 3'd1;
    else if (c2) code = 3'd2;
    else if (c3) code = 3'd3;
    else if (c4) code = 3'd4;
    else if (c5) code = 3'd5;
    else if (c6) code = 3'd6;
    else if (c7) code = 3'd7;
    else         code = 3'd0;

    wr_ptr_d = push ? AW'((int'(wr_ptr_q) + int'(n)) % DEPTH) : wr_ptr_q;
    rd_ptr_d = pop  ? AW'((int'(rd_ptr_q) + 1) % DEPTH)       : rd_ptr_q;
    count_d  = CW'(int'(count_q) + (push ? int'(n) : 0) - (pop ? 1 : 0));
  end

  // Storage is not reset. The pointers and the occupancy define which
  // entries are valid, and a reset discards the contents.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.in_valid[c]) mem_q[AW'((int'(wr_ptr_q) + c) % DEPTH)] <= slot[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      exp_order_q   <= '0;
      commit_q      <= '0;
      idle_q        <= '0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
      code_q        <= 3'd0;
`ifdef MON_PC_CHECK_EN
      last_pc_q     <= '0;
      last_pc_vld_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      idle_q   <= idle_d;
      if (push) begin
        exp_order_q <= exp_order_q + 64'(n);
        commit_q    <= commit_q + 64'(n);
        if (any_halt) halted_q <= 1'b1;
`ifdef MON_PC_CHECK_EN
        last_pc_q     <= last_pc_d;
        last_pc_vld_q <= 1'b1;
`endif
      end
      if (!err_q && code != 3'd0) begin
        err_q  <= 1'b1;
        code_q <= code;
      end
    end
  end

  // The head record comes straight from the storage flops. Its fields are
  // forced to zero while the FIFO is empty, so the outputs read 0 after reset.
  always_comb begin
    head             = mem_q[rd_ptr_q];
    bus.out_valid    = (count_q != '0);
    bus.out_order    = bus.out_valid ? head.order    : '0;
    bus.out_inst     = bus.out_valid ? head.inst     : '0;
    bus.out_pc_rdata = bus.out_valid ? head.pc_rdata : '0;
    bus.out_pc_wdata = bus.out_valid ? head.pc_wdata : '0;
    bus.out_rd_addr  = bus.out_valid ? head.rd_addr  : '0;
    bus.out_rd_wdata = bus.out_valid ? head.rd_wdata : '0;
    bus.out_halt     = bus.out_valid ? head.halt     : 1'b0;
  end

  assign error_o        = err_q;
  assign error_code_o   = code_q;
  assign commit_count_o = commit_q;
  assign halted_o       = halted_q;

endmodule

// File: tb/tb_mon_commit_serializer.sv
module tb_mon_commit_serializer;
  localparam int CH      = 2;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        error;
  logic [2:0]  error_code;
  logic [63:0] commit_count;
  logic        halted;

  always #5 clk = ~clk;

  mon_commit_serializer_if #(.CHANNELS(CH)) bus ();

  mon_commit_serializer #(.CHANNELS(CH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .error_o        (error),
    .error_code_o   (error_code),
    .commit_count_o (commit_count),
    .halted_o       (halted)
  );

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc_r;
    logic [31:0] pc_w;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        halt;
  } rec_t;

  rec_t grp [CH];
  bit   vld [CH];

  rec_t        m_q[$];
  logic [63:0] m_exp, m_count;
  logic [31:0] m_last_pc;
  bit          m_last_vld, m_halted, m_err;
  int          m_idle;
  logic [2:0]  m_code;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_slots();
    for (int c = 0; c < CH; c++) begin
      vld[c] = 1'b0;
      grp[c] = '0;
    end
  endtask

  task automatic set_slot(input int c, input logic [63:0] ord, input logic [31:0] pr,
                          input logic [31:0] pw, input bit h);
    vld[c]      = 1'b1;
    grp[c].order = ord;
    grp[c].inst  = $urandom;
    grp[c].pc_r  = pr;
    grp[c].pc_w  = pw;
    grp[c].rd    = 5'($urandom_range(1, 31));
    grp[c].wd    = $urandom;
    grp[c].halt  = h;
  endtask

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      bus.in_valid[c]             = vld[c];
      bus.in_order[64*c +: 64]    = grp[c].order;
      bus.in_inst[32*c +: 32]     = grp[c].inst;
      bus.in_pc_rdata[32*c +: 32] = grp[c].pc_r;
      bus.in_pc_wdata[32*c +: 32] = grp[c].pc_w;
      bus.in_rd_addr[5*c +: 5]    = grp[c].rd;
      bus.in_rd_wdata[32*c +: 32] = grp[c].wd;
      bus.in_halt[c]              = grp[c].halt;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_slots();
    drive();
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_q.delete();
    m_exp = 0; m_count = 0; m_last_pc = 0; m_last_vld = 0;
    m_halted = 0; m_err = 0; m_idle = 0; m_code = 0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_order", bus.out_order, 0);
    chk("rst_error", error, 0);
    chk("rst_code", error_code, 0);
    chk("rst_count", commit_count, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;
  endtask

  // Compare the DUT against the model state, apply the rules to this cycle's
  // group, then advance one clock.
  task automatic cycle();
    rec_t acc[$];
    int   n;
    bit   c1, c2, c3, c4, c5, c6, c7, push, pop, anyh;
    logic [2:0] code;
    drive();
    chk("out_valid", bus.out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_order", bus.out_order, m_q[0].order);
      chk("out_pcs", {bus.out_pc_rdata, bus.out_pc_wdata}, {m_q[0].pc_r, m_q[0].pc_w});
      chk("out_inst_wd", {bus.out_inst, bus.out_rd_wdata}, {m_q[0].inst, m_q[0].wd});
      chk("out_rd_halt", {bus.out_rd_addr, bus.out_halt}, {m_q[0].rd, m_q[0].halt});
    end
    chk("error", error, m_err);
    chk("error_code", error_code, m_code);
    chk("commit_count", commit_count, m_count);
    chk("halted", halted, m_halted);

    n = 0; c1 = 0; c2 = 0; c3 = 0; c6 = 0; anyh = 0;
    for (int c = 0; c < CH; c++) begin
      if (vld[c]) begin
        n++;
        acc.push_back(grp[c]);
        if (grp[c].order != m_exp + 64'(c)) c1 = 1;
        if (grp[c].rd == 0 && grp[c].wd != 0) c6 = 1;
        if (grp[c].halt) anyh = 1;
      end
      if (c > 0 && vld[c] && !vld[c-1]) c2 = 1;
    end
`ifdef MON_PC_CHECK_EN
    for (int i = 0; i < acc.size(); i++) begin
      if (i > 0 && acc[i].pc_r != acc[i-1].pc_w) c3 = 1;
      if (i == 0 && m_last_vld && acc[i].pc_r != m_last_pc) c3 = 1;
    end
`endif
    c4   = n > (DEPTH - m_q.size());
    c7   = m_halted && n > 0;
    push = n > 0 && !(c2 || c4 || c7);
    pop  = m_q.size() != 0 && bus.out_ready;
    if (push) m_idle = 0;
    else if (!m_halted && m_idle < TIMEOUT) m_idle++;
    c5 = !m_halted && m_idle == TIMEOUT;
    code = c1 ? 1 : c2 ? 2 : c3 ? 3 : c4 ? 4 : c5 ? 5 : c6 ? 6 : c7 ? 7 : 0;
    if (!m_err && code != 0) begin
      m_err  = 1;
      m_code = code;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      foreach (acc[i]) m_q.push_back(acc[i]);
      m_exp      += 64'(n);
      m_count    += 64'(n);
      m_last_pc   = acc[acc.size()-1].pc_w;
      m_last_vld  = 1;
      if (anyh) m_halted = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gen_random();
    int n;
    logic [31:0] pc;
    clear_slots();
    bus.out_ready = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 99) < 15) return;
    n  = $urandom_range(1, CH);
    pc = m_last_vld ? m_last_pc : 32'h1000;
    for (int c = 0; c < n; c++) begin
      set_slot(c, m_exp + 64'(c), pc, pc + 4, $urandom_range(0, 99) < 2);
      pc += 4;
    end
    if ($urandom_range(0, 99) < 4) grp[0].order += 1;
    if ($urandom_range(0, 99) < 3) grp[n-1].pc_r ^= 32'h4;
    if ($urandom_range(0, 99) < 3) begin
      grp[0].rd = 0;
      grp[0].wd = 32'h1 | $urandom;
    end
    if ($urandom_range(0, 99) < 4) begin
      vld[0]    = 1'b0;
      vld[CH-1] = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int drained;
    bus.out_ready = 1'b0;

    // Two full groups stream out in program order.
    do_reset();
    bus.out_ready = 1'b1;
    clear_slots(); set_slot(0, 0, 32'h100, 32'h104, 0); set_slot(1, 1, 32'h104, 32'h108, 0);
    cycle();
    clear_slots(); set_slot(0, 2, 32'h108, 32'h10c, 0); set_slot(1, 3, 32'h10c, 32'h110, 0);
    cycle();
    clear_slots();
    repeat (4) cycle();
    chk("t1_commit", commit_count, 4);
    chk("t1_error", error, 0);

    // An order gap is still pushed, and a later violation keeps code 1.
    do_reset();
    bus.out_ready = 1'b1;
    clear_slots(); set_slot(0, 0, 32'h200, 32'h204, 0); cycle();
    clear_slots(); set_slot(0, 2, 32'h204, 32'h208, 0); cycle();
    clear_slots(); set_slot(1, 1, 32'h208, 32'h20c, 0); cycle();
    clear_slots(); cycle();
    chk("t2_code", error_code, 1);
    chk("t2_commit", commit_count, 2);

    // A non-contiguous group is dropped.
    do_reset();
    clear_slots(); set_slot(1, 1, 32'h300, 32'h304, 0); cycle();
    clear_slots(); cycle();
    chk("t3_code", error_code, 2);
    chk("t3_commit", commit_count, 0);
    chk("t3_empty", bus.out_valid, 0);

    // Overflow drops a whole group, and exactly DEPTH records drain.
    do_reset();
    clear_slots(); set_slot(0, 0, 32'h400, 32'h404, 0); set_slot(1, 1, 32'h404, 32'h408, 0); cycle();
    clear_slots(); set_slot(0, 2, 32'h408, 32'h40c, 0); set_slot(1, 3, 32'h40c, 32'h410, 0); cycle();
    clear_slots(); set_slot(0, 4, 32'h410, 32'h414, 0); set_slot(1, 5, 32'h414, 32'h418, 0); cycle();
    clear_slots();
    chk("t4_code", error_code, 4);
    chk("t4_commit", commit_count, 4);
    bus.out_ready = 1'b1;
    drained = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) drained++;
      cycle();
    end
    chk("t4_drained", drained, 4);

    // PC discontinuity between cycles.
    do_reset();
    bus.out_ready = 1'b1;
    clear_slots(); set_slot(0, 0, 32'h0fc, 32'h100, 0); cycle();
    clear_slots(); set_slot(0, 1, 32'h104, 32'h108, 0); cycle();
    clear_slots(); cycle();
`ifdef MON_PC_CHECK_EN
    chk("t5_code", error_code, 3);
`else
    chk("t5_error", error, 0);
`endif
    chk("t5_commit", commit_count, 2);

    // Timeout fires on the 8th idle cycle after reset release.
    do_reset();
    clear_slots();
    repeat (TIMEOUT - 1) cycle();
    chk("t6_pre_error", error, 0);
    cycle();
    chk("t6_code", error_code, 5);

    // A halt commit freezes the idle counter.
    do_reset();
    clear_slots();
    repeat (3) cycle();
    set_slot(0, 0, 32'h600, 32'h604, 1); cycle();
    clear_slots();
    chk("t7_halted", halted, 1);
    repeat (2 * TIMEOUT) cycle();
    chk("t7_no_timeout", error, 0);

    // Randomized segments checked against the model.
    for (int s = 0; s < 10; s++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        gen_random();
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mon_commit_serializer.md
Name: mon_commit_serializer

Overview:
- Bench-side commit monitor for multi-retire CPUs.
- Accepts up to CHANNELS retirement records per cycle, checks program-order invariants, and buffers the records in a FIFO.
- Emits one record per cycle, in program order, over a valid/ready port to a downstream consumer such as a trace writer or reference model.
- Keeps a sticky first-error code and a commit counter for the testbench.

Parameters:
- CHANNELS, 2: retire slots sampled per cycle; must be ≥1.
- DEPTH, 16: FIFO entries; power of two; must be ≥ CHANNELS.
- TIMEOUT, 10000: idle cycles with no commit before a timeout error; 0 disables the check.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  CHANNELS  per-slot retire valid
- in_order  in  64*CHANNELS  slot c at [64c+63:64c]
- in_inst  in  32*CHANNELS  instruction word
- in_pc_rdata  in  32*CHANNELS  PC of the retiring instruction
- in_pc_wdata  in  32*CHANNELS  next PC
- in_rd_addr  in  5*CHANNELS  destination register
- in_rd_wdata  in  32*CHANNELS  destination write data
- in_halt  in  CHANNELS  halt marker
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts
- out_order  out  64  serialized order field
- out_inst  out  32  serialized inst field
- out_pc_rdata  out  32  serialized pc_rdata field
- out_pc_wdata  out  32  serialized pc_wdata field
- out_rd_addr  out  5  serialized rd_addr field
- out_rd_wdata  out  32  serialized rd_wdata field
- out_halt  out  1  serialized halt field
- error  out  1  sticky; set on first detected violation
- error_code  out  3  code of the first violation
- commit_count  out  64  records accepted into the FIFO
- halted  out  1  a halt record has been accepted

Behaviour:
- Reset: all outputs 0, FIFO empty, expected order 0, last_pc_wdata invalid, idle counter 0.
- Group: the set of valid slots in one cycle; n = popcount(in_valid).
- Group checks, in priority order; the lowest code wins if several fire in the same cycle:
  - 1 order gap: slot k order ≠ expected + k.
  - 2 non-contiguous: in_valid[c]=1 while in_valid[c-1]=0.
  - 3 PC discontinuity: pc_rdata ≠ previous record's pc_wdata. The previous record is the preceding slot, or last_pc_wdata across cycles. The check is skipped for the first record after reset.
  - 4 overflow: n > DEPTH − occupancy. Occupancy is taken before this cycle's pop; no pop credit is given.
  - 5 timeout: idle counter reaches TIMEOUT while halted=0.
  - 6 x0 write: rd_addr=0 with rd_wdata≠0.
  - 7 post-halt: any in_valid while halted=1.
- Error recording:
  - Only the first error is latched.
  - error and error_code hold until rst.
  - Checking continues but no further codes are recorded.
- Push:
  - A group with no code-2, 4 or 7 error is written to the FIFO in slot order.
  - On push: expected += n, commit_count += n, last_pc_wdata ← highest valid slot's pc_wdata.
  - Groups flagged with code 2, 4 or 7 are dropped entirely; expected and the counter are unchanged.
  - Groups flagged with code 1, 3 or 6 are still pushed.
- Latency: a record pushed in cycle N appears at the FIFO head no earlier than cycle N+1. out_* are registered from the FIFO head.
- Pop:
  - Occurs when out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
  - Push and pop in the same cycle are allowed: occupancy += n − pop.
- Full and empty:
  - out_valid=0 when the FIFO is empty.
  - Pointers wrap modulo DEPTH.
  - Full is never entered by a partial group; a group is all-or-nothing.
- Halt: halted goes to 1 the cycle after a group containing in_halt=1 is pushed. Once halted, the timeout counter freezes.
- Idle counter:
  - Clears on any push.
  - Otherwise increments; saturates at TIMEOUT.
  - TIMEOUT=0 disables the counter and the check.
- Reset mid-operation: FIFO contents are discarded, all state returns to reset values, and out_valid=0 in the next cycle.

Optional Feature:
- Macro: MON_PC_CHECK_EN.
- Defined: the code-3 PC continuity check and the last_pc_wdata register are compiled in.
- Undefined: check and register are removed, code 3 is never reported, and all other behaviour is unchanged.

Test Plan:
- CHANNELS=2, two cycles with both slots valid (orders 0,1 then 2,3), out_ready=1 -> orders 0,1,2,3 out in order one per cycle; commit_count=4; error=0.
- Slot0 order 0, then next cycle order 2 -> error=1, error_code=1; record still pushed; later violations do not change the code.
- in_valid=2'b10 -> error_code=2; nothing pushed; commit_count unchanged.
- DEPTH=4, out_ready=0, push 2 groups of 2, then a third group -> error_code=4; FIFO holds 4 records; after out_ready=1 exactly 4 records drain.
- Record pc_wdata=0x100 followed by pc_rdata=0x104 -> code 3 with MON_PC_CHECK_EN defined, no error without it.
- TIMEOUT=8 with no commits -> error_code=5 exactly 8 cycles after reset release; a halt commit before that -> no timeout and halted=1.
